// File: rtl/weight_mem_pkg.sv
// Shared state encodings and default geometry for the
// multi-bank weight store.
package weight_mem_pkg;

   localparam int DEF_BANK_NUM    = 4;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_LAYER_NUM   = 8;
   localparam int DEF_LAYER_DEPTH = 256;

   typedef enum logic {
      L_IDLE,
      L_RUN
   } ld_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_RUN,
      R_DRAIN
   } rd_state_e;

endpackage

// File: rtl/weight_bank_ram.sv
// One weight bank: simple dual-port RAM with a registered
// read port and no reset on the array.
module weight_bank_ram #(
   parameter int DW = 8,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   (* ram_style = "block" *)
   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/weight_bank_mem.sv
// Multi-bank weight store: streaming loader plus
// layer-relative burst reader feeding BANK_NUM weights/cycle.
module weight_bank_mem
   import weight_mem_pkg::*;
#(
   parameter int BANK_NUM    = DEF_BANK_NUM,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int LAYER_NUM   = DEF_LAYER_NUM,
   parameter int LAYER_DEPTH = DEF_LAYER_DEPTH,
   localparam int LW = $clog2(LAYER_NUM),
   localparam int OW = $clog2(LAYER_DEPTH),
   localparam int AW = LW + OW,
   localparam int BW = BANK_NUM * DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          csen,
   input  logic          ld_start,
   input  logic [LW-1:0] ld_layer,
   input  logic [OW:0]   ld_len,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [BW-1:0] ld_data,
   output logic          ld_busy,
   output logic          ld_done,
   input  logic          rd_start,
   input  logic [LW-1:0] rd_layer,
   input  logic [OW-1:0] rd_offset,
   input  logic [OW:0]   rd_len,
   output logic          rd_busy,
   output logic          rd_valid,
   output logic [BW-1:0] rd_data,
   output logic          rd_last,
   output logic          err
);

   localparam logic [OW:0]   DEPTH_L = (OW+1)'(LAYER_DEPTH);
   localparam logic [OW:0]   LEN_ONE = (OW+1)'(1);
   localparam logic [OW-1:0] OFS_ONE = OW'(1);

   ld_state_e     ld_state_q, ld_state_d;
   logic [LW-1:0] ld_layer_q, ld_layer_d;
   logic [OW:0]   ld_len_q, ld_len_d;
   logic [OW-1:0] ld_cnt_q, ld_cnt_d;
   logic          ld_done_q, ld_done_d;
   logic          ld_acc, ld_rej, ld_we;

   rd_state_e     rd_state_q, rd_state_d;
   logic [LW-1:0] rd_layer_q, rd_layer_d;
   logic [OW-1:0] rd_addr_q, rd_addr_d;
   logic [OW:0]   rd_rem_q, rd_rem_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_last_q, rd_last_d;
   logic          rd_rej, rd_ren, rd_ok, rd_conflict;

   logic          err_q, err_d;
   logic [BW-1:0] ram_q;

   assign ld_ready = csen && (ld_state_q == L_RUN);
   assign ld_busy  = (ld_state_q == L_RUN);
   assign ld_we    = ld_valid && ld_ready;

   always_comb begin
      ld_state_d = ld_state_q;
      ld_layer_d = ld_layer_q;
      ld_len_d   = ld_len_q;
      ld_cnt_d   = ld_cnt_q;
      ld_done_d  = 1'b0;
      ld_acc     = 1'b0;
      ld_rej     = 1'b0;
      unique case (ld_state_q)
         L_IDLE: begin
            if (csen && ld_start) begin
               if (ld_len != '0 && ld_len <= DEPTH_L) begin
                  ld_acc     = 1'b1;
                  ld_layer_d = ld_layer;
                  ld_len_d   = ld_len;
                  ld_cnt_d   = '0;
                  ld_state_d = L_RUN;
               end else begin
                  ld_rej = 1'b1;
               end
            end
         end
         L_RUN: begin
            if (ld_we) begin
               ld_cnt_d = ld_cnt_q + OFS_ONE;
               if ({1'b0, ld_cnt_q} == ld_len_q - LEN_ONE) begin
                  ld_state_d = L_IDLE;
                  ld_done_d  = 1'b1;
               end
            end
         end
         default: ld_state_d = L_IDLE;
      endcase
   end

   // The load wins a same-layer tie, so reads must see this cycle's accept too.
   assign rd_conflict = (ld_busy && rd_layer == ld_layer_q)
                     || (ld_acc && rd_layer == ld_layer);
   assign rd_ok = (rd_len != '0)
               && (({1'b0, rd_offset} + rd_len) <= DEPTH_L)
               && !rd_conflict;

   always_comb begin
      rd_state_d = rd_state_q;
      rd_layer_d = rd_layer_q;
      rd_addr_d  = rd_addr_q;
      rd_rem_d   = rd_rem_q;
      rd_last_d  = 1'b0;
      rd_ren     = 1'b0;
      rd_rej     = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            if (csen && rd_start) begin
               if (rd_ok) begin
                  rd_layer_d = rd_layer;
                  rd_addr_d  = rd_offset;
                  rd_rem_d   = rd_len;
                  rd_state_d = R_RUN;
               end else begin
                  rd_rej = 1'b1;
               end
            end
         end
         R_RUN: begin
            if (csen) begin
               rd_ren    = 1'b1;
               rd_addr_d = rd_addr_q + OFS_ONE;
               rd_rem_d  = rd_rem_q - LEN_ONE;
               if (rd_rem_q == LEN_ONE) begin
                  rd_last_d  = 1'b1;
                  rd_state_d = R_DRAIN;
               end
            end
         end
         R_DRAIN: begin
            if (csen) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   assign rd_valid_d = rd_ren;
   assign err_d      = ld_rej || rd_rej;

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state_q <= L_IDLE;
         ld_layer_q <= '0;
         ld_len_q   <= '0;
         ld_cnt_q   <= '0;
         ld_done_q  <= 1'b0;
         rd_state_q <= R_IDLE;
         rd_layer_q <= '0;
         rd_addr_q  <= '0;
         rd_rem_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ld_state_q <= ld_state_d;
         ld_layer_q <= ld_layer_d;
         ld_len_q   <= ld_len_d;
         ld_cnt_q   <= ld_cnt_d;
         ld_done_q  <= ld_done_d;
         rd_state_q <= rd_state_d;
         rd_layer_q <= rd_layer_d;
         rd_addr_q  <= rd_addr_d;
         rd_rem_q   <= rd_rem_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         err_q      <= err_d;
      end
   end

   for (genvar k = 0; k < BANK_NUM; k++) begin : g_bank
      weight_bank_ram #(
         .DW (DATA_WIDTH),
         .AW (AW)
      ) u_ram (
         .clk   (clk),
         .we    (ld_we),
         .waddr ({ld_layer_q, ld_cnt_q}),
         .wdata (ld_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .re    (rd_ren),
         .raddr ({rd_layer_q, rd_addr_q}),
         .rdata (ram_q[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign ld_done  = ld_done_q;
   assign rd_busy  = (rd_state_q != R_IDLE);
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_data  = rd_valid_q ? ram_q : '0;
   assign err      = err_q;

endmodule

// File: tb/tb_weight_bank_mem.sv
// Scoreboard bench for weight_bank_mem: loads are mirrored into
// a model memory, read beats are queued and checked at negedge.
module tb_weight_bank_mem;

   logic        clk = 1'b0;
   logic        rst, csen;
   logic        ld_start, ld_valid, ld_ready, ld_busy, ld_done;
   logic [2:0]  ld_layer, rd_layer;
   logic [8:0]  ld_len, rd_len;
   logic [7:0]  rd_offset;
   logic [31:0] ld_data, rd_data;
   logic        rd_start, rd_busy, rd_valid, rd_last, err;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [31:0] mem_m [8][256];
   logic [32:0] expq [$];

   always #5 clk = ~clk;

   weight_bank_mem dut (
      .clk       (clk),
      .rst       (rst),
      .csen      (csen),
      .ld_start  (ld_start),
      .ld_layer  (ld_layer),
      .ld_len    (ld_len),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_data   (ld_data),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done),
      .rd_start  (rd_start),
      .rd_layer  (rd_layer),
      .rd_offset (rd_offset),
      .rd_len    (rd_len),
      .rd_busy   (rd_busy),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .err       (err)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word(input int layer, input int i);
      int o;
      o = (layer == 2) ? 0 : layer * 32;
      return {8'(i + 4 + o), 8'(i + 3 + o), 8'(i + 2 + o), 8'(i + 1 + o)};
   endfunction

   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst && mon_en) begin
         if (rd_valid) begin
            if (expq.size() == 0) begin
               check("rd_extra_beat", 1, 0);
            end else begin
               e = expq.pop_front();
               check("rd_data", rd_data, e[31:0]);
               check("rd_last", rd_last, e[32]);
            end
         end else begin
            check("rd_zero", rd_data, 0);
            check("rd_last_idle", rd_last, 0);
         end
      end
   end

   task automatic do_load(input int layer, input int len, input bit tog,
                          input int rdy_exp);
      int i, cyc, rdy;
      bit hs, v;
      i = 0; cyc = 0; rdy = 0; v = 1'b1;
      ld_start = 1'b1; ld_layer = 3'(layer); ld_len = 9'(len);
      tick();
      ld_start = 1'b0;
      check("ld_busy", ld_busy, 1);
      while (i < len && cyc < 1000) begin
         ld_valid = v;
         ld_data  = word(layer, i);
         hs = ld_valid && ld_ready;
         if (ld_ready) rdy++;
         if (hs) mem_m[layer][i] = ld_data;
         tick();
         if (hs) i++;
         if (tog) v = !v;
         cyc++;
      end
      ld_valid = 1'b0;
      check("ld_writes", i, len);
      check("ld_done", ld_done, 1);
      if (rdy_exp > 0) check("ld_rdy_cycles", rdy, rdy_exp);
      tick();
      check("ld_done_once", ld_done, 0);
      check("ld_idle", ld_busy, 0);
   endtask

   task automatic do_read(input int layer, input int off, input int len,
                          input bit ok, input int stall);
      int busy_n;
      rd_start = 1'b1; rd_layer = 3'(layer);
      rd_offset = 8'(off); rd_len = 9'(len);
      if (ok)
         for (int i = 0; i < len; i++)
            expq.push_back({i == len - 1, mem_m[layer][off + i]});
      tick();
      rd_start = 1'b0;
      if (!ok) begin
         check("rd_err", err, 1);
         check("rd_rej_busy", rd_busy, 0);
         tick();
         check("rd_err_once", err, 0);
         return;
      end
      check("rd_busy", rd_busy, 1);
      check("rd_lat_t1", rd_valid, 0);
      busy_n = 0;
      while (rd_busy && busy_n < 600) begin
         if (busy_n == 1) check("rd_lat_t2", rd_valid, 1);
         csen = !(stall > 0 && busy_n >= 2 && busy_n < 2 + stall);
         busy_n++;
         tick();
      end
      csen = 1'b1;
      check("rd_busy_cycles", busy_n, len + 1 + stall);
      check("sb_drained", expq.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; csen = 1'b1;
      ld_start = 0; ld_valid = 0; ld_layer = 0; ld_len = 0; ld_data = 0;
      rd_start = 0; rd_layer = 0; rd_offset = 0; rd_len = 0;
      tick(); tick();
      check("rst_busy", {ld_busy, rd_busy, ld_ready}, 0);
      check("rst_flags", {ld_done, rd_valid, rd_last, err}, 0);
      check("rst_data", rd_data, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      do_load(2, 4, 1'b0, 4);
      check("word0", mem_m[2][0], 32'h04030201);
      do_read(2, 0, 4, 1'b1, 0);

      do_load(1, 8, 1'b1, 15);
      do_read(1, 5, 3, 1'b1, 0);

      fork
         do_load(3, 8, 1'b0, 8);
         begin
            tick(); tick();
            do_read(3, 0, 4, 1'b0, 0);
            do_read(1, 0, 8, 1'b1, 0);
         end
      join
      do_read(3, 0, 8, 1'b1, 0);

      do_load(0, 256, 1'b0, 256);
      do_read(0, 250, 10, 1'b0, 0);
      do_read(0, 0, 0, 1'b0, 0);
      do_read(0, 255, 1, 1'b1, 0);
      do_read(0, 0, 256, 1'b1, 0);

      fork
         do_load(4, 2, 1'b0, 2);
         do_read(4, 0, 2, 1'b0, 0);
      join

      ld_start = 1'b1; ld_layer = 6; ld_len = 0;
      rd_start = 1'b1; rd_layer = 6; rd_offset = 0; rd_len = 0;
      tick();
      ld_start = 1'b0; rd_start = 1'b0;
      check("err_both", err, 1);
      check("ld_rej_idle", ld_busy, 0);
      tick();
      check("err_both_once", err, 0);

      do_read(1, 1, 6, 1'b1, 2);

      mon_en = 1'b0;
      ld_start = 1'b1; ld_layer = 5; ld_len = 8;
      rd_start = 1'b1; rd_layer = 1; rd_offset = 0; rd_len = 8;
      tick();
      ld_start = 1'b0; rd_start = 1'b0;
      ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
      tick(); tick(); tick();
      check("mid_busy", {ld_busy, rd_busy}, 2'b11);
      rst = 1'b1;
      tick();
      check("mrst_busy", {ld_busy, rd_busy, ld_ready}, 0);
      check("mrst_flags", {ld_done, rd_valid, rd_last, err}, 0);
      check("mrst_data", rd_data, 0);
      rst = 1'b0; ld_valid = 1'b0;
      expq.delete();
      tick();
      check("post_rst_idle", {ld_busy, rd_busy, rd_valid}, 0);
      mon_en = 1'b1;

      do_read(2, 0, 4, 1'b1, 0);
      do_read(1, 0, 8, 1'b1, 0);
      do_read(3, 0, 8, 1'b1, 0);

      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_bank_mem.md
Name: weight_bank_mem

Overview:
- Parametrised multi-bank weight store for the ECG accelerator. It holds the weights of all layers in BANK_NUM parallel banks.
- Weights are loaded through a synthesizable streaming valid/ready port, so no simulation-only file loading is involved.
- Reads are issued as layer-relative bursts that feed the PE array with BANK_NUM weights per cycle.
- Sits between the weight loader / DMA and the conv/FC compute array. It replaces the per-bank single-port weight memories.

Parameters:
- BANK_NUM, 4, number of parallel weight banks (weights delivered per cycle)
- DATA_WIDTH, 8, bits per weight
- LAYER_NUM, 8, number of layer regions
- LAYER_DEPTH, 256, words per bank per layer region (power of 2)
- LW (local), clog2(LAYER_NUM), layer index width
- OW (local), clog2(LAYER_DEPTH), offset width
- AW (local), LW+OW, bank address width; physical address = {layer, offset}

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csen  in  1  chip enable; low freezes both FSMs
- ld_start  in  1  begin load of one layer region
- ld_layer  in  LW  layer to load
- ld_len  in  OW+1  words to load, 1..LAYER_DEPTH
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  load word accepted when ld_valid & ld_ready
- ld_data  in  BANK_NUM*DATA_WIDTH  one word per bank; bank k = bits [k*DW +: DW]
- ld_busy  out  1  load in progress
- ld_done  out  1  one-cycle pulse after last load word is written
- rd_start  in  1  begin read burst
- rd_layer  in  LW  layer to read
- rd_offset  in  OW  first word offset
- rd_len  in  OW+1  burst length, 1..LAYER_DEPTH
- rd_busy  out  1  burst in progress, including the data-drain cycle
- rd_valid  out  1  rd_data valid
- rd_data  out  BANK_NUM*DATA_WIDTH  weights; all zero when rd_valid=0
- rd_last  out  1  marks final beat of burst
- err  out  1  one-cycle pulse on a rejected ld_start or rd_start

Behaviour:
- Reset (rst=1 at a clk edge): both FSMs go to IDLE. ld_ready, ld_busy, ld_done, rd_busy, rd_valid, rd_last, err = 0; rd_data = 0. RAM contents are not cleared. A reset in mid-operation aborts it; a partially loaded region holds mixed old and new data.
- Load FSM L_IDLE -> L_RUN -> L_IDLE:
  - In L_IDLE with csen=1, ld_start is accepted iff 1 <= ld_len <= LAYER_DEPTH. Otherwise err pulses next cycle and the FSM stays in L_IDLE.
  - On accept, latch layer/len and clear the word counter. ld_busy=1 from the next cycle.
  - In L_RUN, ld_ready = csen. Each handshake writes ld_data to address {layer, cnt} in every bank, then cnt increments.
  - The handshake with cnt == len-1 returns the FSM to L_IDLE. ld_done pulses the cycle after it.
  - ld_start while busy is ignored; no err.
- Read FSM R_IDLE -> R_RUN -> R_DRAIN -> R_IDLE:
  - rd_start in R_IDLE with csen=1 is accepted iff all of: 1 <= rd_len; rd_offset + rd_len <= LAYER_DEPTH; not (ld_busy and rd_layer == latched ld layer).
  - A simultaneous ld_start and rd_start on the same layer: the load is accepted and the read is rejected.
  - A rejected rd_start pulses err next cycle. If ld_start and rd_start are both rejected in the same cycle, err pulses once.
  - Accept at cycle T: addresses offset .. offset+len-1 are issued in cycles T+1 .. T+len.
  - RAM read latency is 1, so rd_valid is high in cycles T+2 .. T+len+1 and rd_last is high at T+len+1.
  - R_DRAIN is a single cycle and covers the last data beat. rd_busy is high T+1 .. T+len+1.
  - rd_start while busy is ignored.
- csen=0:
  - No new starts are accepted and ld_ready=0.
  - The read address counter holds and rd_valid=0 for the affected beats, so the burst is stretched with no beat lost or repeated.
  - A data beat already in flight from the previous cycle is still presented.
- Offset arithmetic is OW+1 bits; no wrap across regions can occur because the range check rejects such bursts.
- Read and write to different layers proceed concurrently. There is no same-address hazard because reads to the loading layer are rejected.

Decomposition:
- Package weight_mem_pkg holds:
  - load/read state encodings (L_IDLE, L_RUN; R_IDLE, R_RUN, R_DRAIN)
  - the default BANK_NUM, DATA_WIDTH, LAYER_NUM, LAYER_DEPTH constants
- Sub-module weight_bank_ram: simple dual-port RAM (1 write port, 1 registered read port, ram_style block, no reset on the array). It is instantiated BANK_NUM times by a generate loop.
- Both FSMs and the range checks live in the top.

Test Plan:
- Load layer 2 with len=4 and words 0x04030201 .. 0x07060504 back-to-back -> ld_ready high 4 cycles, ld_done pulses once; read layer 2 offset 0 len 4 -> rd_valid 4 consecutive cycles starting T+2 with the same words, rd_last on the 4th.
- Load layer 1 len=8 while ld_valid toggles 1,0,1,0 -> exactly 8 writes and ld_done after the 8th handshake; readback offset 5 len 3 returns words 5,6,7.
- During the layer 3 load, rd_start on layer 3 -> err pulse, no rd_busy; rd_start on layer 1 in the same window -> burst proceeds with correct data.
- rd_start with layer 0, offset 250, len 10 (LAYER_DEPTH=256) -> err; len 0 -> err; offset 255, len 1 -> single beat with rd_last.
- Read len=6 with csen low for 2 cycles mid-burst -> 6 valid beats in address order, burst 2 cycles longer, rd_data=0 on non-valid cycles.
- rst asserted mid-burst and mid-load -> next cycle all outputs 0 and FSMs idle; previously fully loaded layers read back unchanged.
